// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO FIFO block: register map, control bit
// positions, status register layout and the read transaction id type.
package mmio_fifo_pkg;

   localparam logic [15:0] ADDR_DATA_DEF = 16'h0020;
   localparam logic [15:0] ADDR_STAT_DEF = 16'h0022;
   localparam logic [15:0] ADDR_CTRL_DEF = 16'h0024;

   localparam int CTRL_FLUSH      = 0;
   localparam int CTRL_CLR_STICKY = 1;

   typedef logic [8:0] t_mmio_tid;

   typedef struct packed {
      logic       udf;
      logic       ovf;
      logic       full;
      logic       empty;
      logic [7:0] count;
   } t_fifo_status;

endpackage

// File: rtl/fifo_core.sv
// Circular FIFO storage with registered occupancy, full and empty flags.
// A pop frees a slot for a same-cycle push; flush discards everything.
module fifo_core
   import mmio_fifo_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              push_ok,
   output logic              pop_ok,
   output logic [7:0]        count,
   output logic              full,
   output logic              empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;

   assign pop_ok  = pop && !empty_q;
   assign push_ok = push && (!full_q || pop_ok);
   assign rd_data = mem[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr_q] <= wdata;
   end

   assign count = 8'(count_q);
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/mmio_fifo_csr.sv
// MMIO front end for the FIFO: address decode, sticky overflow/underflow
// flags, flush control and the registered read response.
module mmio_fifo_csr
   import mmio_fifo_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter int          DATA_W    = 64,
   parameter logic [15:0] ADDR_DATA = ADDR_DATA_DEF,
   parameter logic [15:0] ADDR_STAT = ADDR_STAT_DEF,
   parameter logic [15:0] ADDR_CTRL = ADDR_CTRL_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mmio_wr_valid,
   input  logic              mmio_rd_valid,
   input  logic [15:0]       mmio_addr,
   input  logic [DATA_W-1:0] mmio_wdata,
   input  t_mmio_tid         mmio_tid,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output t_mmio_tid         rsp_tid,
   output logic [7:0]        count,
   output logic              full,
   output logic              empty
);

   logic push, pop, flush, clr_sticky, ctrl_wr;
   logic push_ok, pop_ok;
   logic [DATA_W-1:0] fifo_rd_data;
   logic ovf_q, ovf_d, udf_q, udf_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   t_mmio_tid         rsp_tid_q, rsp_tid_d;
   t_fifo_status      status;

   assign push       = mmio_wr_valid && (mmio_addr == ADDR_DATA);
   assign pop        = mmio_rd_valid && (mmio_addr == ADDR_DATA);
   assign ctrl_wr    = mmio_wr_valid && (mmio_addr == ADDR_CTRL);
   assign flush      = ctrl_wr && mmio_wdata[CTRL_FLUSH];
   assign clr_sticky = ctrl_wr && mmio_wdata[CTRL_CLR_STICKY];

   fifo_core #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wdata   (mmio_wdata),
      .rd_data (fifo_rd_data),
      .push_ok (push_ok),
      .pop_ok  (pop_ok),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   assign status = '{udf: udf_q, ovf: ovf_q, full: full, empty: empty, count: count};

   // Clear is applied first so a same-cycle set takes priority.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (clr_sticky) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (push && !push_ok) ovf_d = 1'b1;
      if (pop && empty)     udf_d = 1'b1;
   end

   always_comb begin
      rsp_valid_d = mmio_rd_valid;
      rsp_data_d  = rsp_data_q;
      rsp_tid_d   = rsp_tid_q;
      if (mmio_rd_valid) begin
         rsp_tid_d = mmio_tid;
         if (mmio_addr == ADDR_DATA)
            rsp_data_d = pop_ok ? fifo_rd_data : '0;
         else if (mmio_addr == ADDR_STAT)
            rsp_data_d = {{(DATA_W - $bits(t_fifo_status)){1'b0}}, status};
         else
            rsp_data_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tid_q   <= '0;
      end else begin
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tid_q   <= rsp_tid_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_tid   = rsp_tid_q;

endmodule

// File: tb/tb_mmio_fifo_csr.sv
// Directed self-checking bench for mmio_fifo_csr (DEPTH=8), using immediate
// assertions with hand-computed expected values.
module tb_mmio_fifo_csr;

   localparam logic [15:0] A_DATA = 16'h0020;
   localparam logic [15:0] A_STAT = 16'h0022;
   localparam logic [15:0] A_CTRL = 16'h0024;

   logic        clk;
   logic        rst;
   logic        mmio_wr_valid;
   logic        mmio_rd_valid;
   logic [15:0] mmio_addr;
   logic [63:0] mmio_wdata;
   logic [8:0]  mmio_tid;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic [8:0]  rsp_tid;
   logic [7:0]  count;
   logic        full;
   logic        empty;

   int checksTotal;
   int checksPassed;

   mmio_fifo_csr dut (
      .clk           (clk),
      .rst           (rst),
      .mmio_wr_valid (mmio_wr_valid),
      .mmio_rd_valid (mmio_rd_valid),
      .mmio_addr     (mmio_addr),
      .mmio_wdata    (mmio_wdata),
      .mmio_tid      (mmio_tid),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_tid       (rsp_tid),
      .count         (count),
      .full          (full),
      .empty         (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checksTotal++;
      assert (observed === expected) checksPassed++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // One bus cycle: drive strobes, let the edge take them, sample 1 ns later.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                                input logic [63:0] wdata, input logic [8:0] tid);
      mmio_wr_valid = wr;
      mmio_rd_valid = rd;
      mmio_addr     = addr;
      mmio_wdata    = wdata;
      mmio_tid      = tid;
      @(posedge clk);
      #1;
      mmio_wr_valid = 1'b0;
      mmio_rd_valid = 1'b0;
   endtask

   task automatic mmioWrite(input logic [15:0] addr, input logic [63:0] wdata);
      applyStimulus(1'b1, 1'b0, addr, wdata, 9'h0);
   endtask

   task automatic readCheck(input string tag, input logic [15:0] addr, input logic [8:0] tid,
                            input logic [63:0] expData);
      applyStimulus(1'b0, 1'b1, addr, 64'h0, tid);
      checkOutput({tag, ".valid"}, 64'(rsp_valid), 64'h1);
      checkOutput({tag, ".data"}, rsp_data, expData);
      checkOutput({tag, ".tid"}, 64'(rsp_tid), 64'(tid));
   endtask

   initial begin
      checksTotal   = 0;
      checksPassed  = 0;
      rst           = 1'b1;
      mmio_wr_valid = 1'b0;
      mmio_rd_valid = 1'b0;
      mmio_addr     = 16'h0;
      mmio_wdata    = 64'h0;
      mmio_tid      = 9'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.rsp_valid", 64'(rsp_valid), 64'h0);
      checkOutput("reset.rsp_data", rsp_data, 64'h0);
      checkOutput("reset.rsp_tid", 64'(rsp_tid), 64'h0);
      checkOutput("reset.count", 64'(count), 64'h0);
      checkOutput("reset.full", 64'(full), 64'h0);
      checkOutput("reset.empty", 64'(empty), 64'h1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Status after reset, then the response must be a single-cycle pulse.
      readCheck("stat_reset", A_STAT, 9'h155, 64'h100);
      @(posedge clk);
      #1;
      checkOutput("rsp_pulse_one_cycle", 64'(rsp_valid), 64'h0);

      // In-order push/pop.
      mmioWrite(A_DATA, 64'hA);
      mmioWrite(A_DATA, 64'hB);
      mmioWrite(A_DATA, 64'hC);
      checkOutput("count_after_3_push", 64'(count), 64'd3);
      readCheck("pop_A", A_DATA, 9'h001, 64'hA);
      checkOutput("count_after_pop_A", 64'(count), 64'd2);
      readCheck("pop_B", A_DATA, 9'h002, 64'hB);
      readCheck("pop_C", A_DATA, 9'h003, 64'hC);
      checkOutput("count_after_pop_C", 64'(count), 64'd0);
      checkOutput("empty_after_pop_C", 64'(empty), 64'h1);

      // Overflow: 9th word dropped.
      for (int i = 1; i <= 9; i++) mmioWrite(A_DATA, 64'(i));
      checkOutput("full_after_9_push", 64'(full), 64'h1);
      readCheck("stat_ovf", A_STAT, 9'h010, 64'h608);
      for (int i = 1; i <= 8; i++) readCheck($sformatf("drain_ovf_%0d", i), A_DATA, 9'(i), 64'(i));
      mmioWrite(A_CTRL, 64'h2);
      readCheck("stat_after_clr", A_STAT, 9'h011, 64'h100);

      // Underflow, then simultaneous push+pop on an empty FIFO.
      readCheck("pop_empty", A_DATA, 9'h020, 64'h0);
      readCheck("stat_udf", A_STAT, 9'h021, 64'h900);
      mmioWrite(A_CTRL, 64'h2);
      applyStimulus(1'b1, 1'b1, A_DATA, 64'hEE, 9'h022);
      checkOutput("pushpop_empty.data", rsp_data, 64'h0);
      checkOutput("pushpop_empty.count", 64'(count), 64'd1);
      readCheck("stat_pushpop_empty", A_STAT, 9'h023, 64'h801);
      readCheck("pop_EE", A_DATA, 9'h024, 64'hEE);
      mmioWrite(A_CTRL, 64'h2);

      // Push+pop on a full FIFO: no overflow, count stays at depth.
      for (int i = 0; i < 8; i++) mmioWrite(A_DATA, 64'h100 + 64'(i));
      applyStimulus(1'b1, 1'b1, A_DATA, 64'h55, 9'h030);
      checkOutput("pushpop_full.data", rsp_data, 64'h100);
      checkOutput("pushpop_full.count", 64'(count), 64'd8);
      readCheck("stat_pushpop_full", A_STAT, 9'h031, 64'h208);
      for (int i = 1; i < 8; i++) readCheck($sformatf("drain_full_%0d", i), A_DATA, 9'h040, 64'h100 + 64'(i));
      readCheck("drain_full_55", A_DATA, 9'h048, 64'h55);

      // Unmapped read and ignored writes.
      readCheck("unmapped_read", 16'h0030, 9'h1FF, 64'h0);
      mmioWrite(A_DATA, 64'h99);
      mmioWrite(A_STAT, 64'hFFFF);
      mmioWrite(16'h0030, 64'hFFFF);
      checkOutput("ignored_writes.count", 64'(count), 64'd1);
      readCheck("pop_99", A_DATA, 9'h050, 64'h99);

      // Flush.
      for (int i = 0; i < 5; i++) mmioWrite(A_DATA, 64'h200 + 64'(i));
      checkOutput("count_before_flush", 64'(count), 64'd5);
      mmioWrite(A_CTRL, 64'h1);
      checkOutput("flush.count", 64'(count), 64'd0);
      checkOutput("flush.empty", 64'(empty), 64'h1);
      mmioWrite(A_DATA, 64'h77);
      readCheck("pop_77", A_DATA, 9'h060, 64'h77);

      // Pointer wrap-around.
      for (int i = 0; i < 20; i++) begin
         mmioWrite(A_DATA, 64'h1000 + 64'(i * 3));
         readCheck($sformatf("wrap_%0d", i), A_DATA, 9'(i), 64'h1000 + 64'(i * 3));
      end
      checkOutput("wrap.empty", 64'(empty), 64'h1);

      // Reset mid-stream drops the pending response and contents.
      mmioWrite(A_DATA, 64'h31);
      mmioWrite(A_DATA, 64'h32);
      mmioWrite(A_DATA, 64'h33);
      applyStimulus(1'b0, 1'b1, A_DATA, 64'h0, 9'h070);
      checkOutput("pre_rst.rsp_valid", 64'(rsp_valid), 64'h1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst.rsp_valid", 64'(rsp_valid), 64'h0);
      checkOutput("mid_rst.count", 64'(count), 64'd0);
      checkOutput("mid_rst.empty", 64'(empty), 64'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      readCheck("pop_after_rst", A_DATA, 9'h071, 64'h0);
      readCheck("stat_after_rst", A_STAT, 9'h072, 64'h900);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/mmio_fifo_csr.md
Name: mmio_fifo_csr

Overview:
- MMIO-mapped FIFO with status/control registers, downstream of the AFU's CCI-P MMIO header decode.
- Host pushes 64-bit words by MMIO write and pops them by MMIO read of the same address.
- Returns a registered read response (data + tid) that the AFU forwards onto Tx c2.
- Adds occupancy, full/empty and sticky overflow/underflow status, plus flush control.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..128
DATA_W, 64, word width
ADDR_DATA, 16'h0020, push (write) / pop (read) address
ADDR_STAT, 16'h0022, status register, read-only
ADDR_CTRL, 16'h0024, control register, write-only

Ports:
clk  input  1  clock
rst  input  1  reset
mmio_wr_valid  input  1  MMIO write strobe, one cycle
mmio_rd_valid  input  1  MMIO read strobe, one cycle
mmio_addr  input  16  decoded MMIO word address
mmio_wdata  input  64  write data
mmio_tid  input  9  read transaction id
rsp_valid  output  1  read response valid, one-cycle pulse
rsp_data  output  64  read response data
rsp_tid  output  9  echoed tid
count  output  8  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset: rsp_valid=0, rsp_data=0, rsp_tid=0, count=0, full=0, empty=1. Read/write pointers=0; ovf and udf sticky flags=0. Storage array is not reset.
- Write to ADDR_DATA:
  - If not full, or a pop is accepted in the same cycle: store wdata at wr_ptr; wr_ptr advances and wraps modulo DEPTH.
  - Otherwise: drop the data and set ovf.
- Write to ADDR_CTRL:
  - bit0=1 (flush): pointers and count go to 0 next cycle; any same-cycle push is discarded.
  - bit1=1: clear ovf and udf. If set and clear coincide, set wins.
  - Other bits are ignored.
- Writes to ADDR_STAT or unmapped addresses are ignored.
- Read: rsp_valid pulses exactly 1 cycle after mmio_rd_valid, with rsp_tid=mmio_tid. Every read gets a response, including unmapped addresses (data 0).
- Read of ADDR_DATA:
  - If not empty: rsp_data = mem[rd_ptr]; rd_ptr advances and wraps.
  - If empty: rsp_data=0 and udf is set. There is no bypass from a same-cycle push.
- Read of ADDR_STAT: rsp_data = {52'b0, udf, ovf, full, empty, count[7:0]}, sampled as pre-update state for the same cycle.
- Simultaneous push and pop (wr and rd strobes both set):
  - Not empty, not full: both occur, count unchanged.
  - Full: pop occurs, push accepted, count stays DEPTH, no ovf.
  - Empty: push accepted, pop returns 0 and sets udf, count becomes 1.
- Flush concurrent with pop: the pop response still returns mem[rd_ptr] if it was non-empty, then the FIFO is empty.
- Count arithmetic: next = count + push_ok - pop_ok. Width $clog2(DEPTH)+1, zero-extended to 8 bits. full, empty and count are registered and consistent in the same cycle.
- Reset asserted mid-operation: pending response dropped (rsp_valid=0 immediately), contents logically lost.

Decomposition:
- Shared package mmio_fifo_pkg holds:
  - address constants and CTRL bit indices (FLUSH=0, CLR_STICKY=1);
  - a t_fifo_status packed struct {udf, ovf, full, empty, count};
  - t_mmio_tid typedef (9 bits).
- One sub-module, fifo_core: pointers, count and storage, with push/pop/flush inputs.
- mmio_fifo_csr holds the address decode, sticky flags and response register.

Test Plan:
- Reset, then read STAT -> rsp 1 cycle later, data 0x100 (empty=1), tid echoed.
- Push 0xA,0xB,0xC, then pop x3 -> rsp_data 0xA,0xB,0xC in order; count 3->0; empty=1.
- Push 9 words with DEPTH=8 -> 9th dropped; STAT=0x608 (full, ovf, count 8). Then pop 8 -> words 1..8. Write CTRL=0x2 -> STAT=0x100.
- Pop when empty -> rsp_data 0, udf=1 (STAT 0x900). Push+pop same cycle when empty -> pop returns 0, count=1.
- Full FIFO, push 0x55 and pop same cycle -> pop returns oldest word, count stays 8, ovf=0. Then drain 8 -> 0x55 comes out last.
- Push 5, write CTRL=0x1 -> count 0, empty=1. Push 0x77, pop -> 0x77; wrap-around verified by 20 push/pop pairs. Assert rst mid-stream -> count 0, rsp_valid 0.
